// File: rtl/i4002_bank.sv
// i4002_bank: MCS-4 data-RAM bank of NUM_CHIPS 4002-style chips on one cm_ram line.
// Each chip holds REGS_PER_CHIP registers of CHARS_PER_REG data characters
// plus STATUS_PER_REG status characters, and a 4-bit output port.
// A clear walker zeroes every storage location after reset or on clr_req.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset (forces the clear walk)
//   sync     instruction-cycle sync; the next cycle is A1
//   cm_ram   RAM command line for this bank
//   clr_req  one-cycle pulse restarting the clear walk
//   dbus_in  data bus from the CPU
//   dbus_out read data, driven only during X2 of a read, else 0
//   io_out   output ports, chip k in bits [4k+3:4k]
//   busy     clear walk in progress

package mcs4;
  typedef logic [3:0] char_t;
  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

  localparam char_t OP_WRM = 4'h0;
  localparam char_t OP_WMP = 4'h1;
  localparam char_t OP_SBM = 4'h8;
  localparam char_t OP_RDM = 4'h9;
  localparam char_t OP_ADM = 4'hB;
endpackage

module i4002_bank #(
  parameter int NUM_CHIPS      = 4,
  parameter int CHIP_ID_BASE   = 0,
  parameter int REGS_PER_CHIP  = 4,
  parameter int CHARS_PER_REG  = 16,
  parameter int STATUS_PER_REG = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync,
  input  logic                   cm_ram,
  input  logic                   clr_req,
  input  mcs4::char_t            dbus_in,
  output mcs4::char_t            dbus_out,
  output logic [4*NUM_CHIPS-1:0] io_out,
  output logic                   busy
);
  import mcs4::*;

  // Data characters occupy the low part of one flat store, status the rest,
  // both chip-major, so the clear walk index is the store address directly.
  localparam int DATA_TOT = NUM_CHIPS*REGS_PER_CHIP*CHARS_PER_REG;
  localparam int TOTAL    = NUM_CHIPS*REGS_PER_CHIP*(CHARS_PER_REG+STATUS_PER_REG);
  localparam int WW       = $clog2(TOTAL+1);
  localparam int IW       = $clog2(TOTAL);
  localparam logic [WW-1:0] LAST = WW'(TOTAL-1);

  typedef enum logic {RUN, CLEAR} state_t;

  instr_cyc_t              cyc_q;
  logic                    src_hit_q, opa_valid_q;
  char_t                   addr_hi_q, addr_lo_q, opa_q, rd_q, rd_d;
  logic [NUM_CHIPS-1:0][3:0] io_q;
  state_t                  state_q, state_d;
  logic [WW-1:0]           walk_q, walk_d;
  logic [3:0]              store_q [TOTAL];

  int            chip_k;
  logic          chip_ok, data_ok, st_ok, running;
  logic          op_rd_data, op_rd_st, op_wr_data, op_wr_st, op_wmp;
  logic          bus_wr, we_data, we_st, we_io;
  logic [IW-1:0] data_idx, st_idx;

  // Phase counter, SRC/command latches and read register keep running in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q       <= A1;
      src_hit_q   <= 1'b0;
      addr_hi_q   <= '0;
      addr_lo_q   <= '0;
      opa_valid_q <= 1'b0;
      opa_q       <= '0;
      rd_q        <= '0;
    end else begin
      cyc_q <= sync ? A1 : instr_cyc_t'(cyc_q + 3'd1);
      if (cyc_q == X2) begin
        src_hit_q <= cm_ram;
        if (cm_ram) addr_hi_q <= dbus_in;
      end
      if (cyc_q == X3 && src_hit_q) addr_lo_q <= dbus_in;
      if (cyc_q == M2) begin
        opa_valid_q <= cm_ram;
        if (cm_ram) opa_q <= dbus_in;
      end
      // Loaded only at X1, so it is non-zero for the X2 cycle alone.
      rd_q <= (cyc_q == X1) ? rd_d : '0;
    end
  end

  always_comb begin
    running    = (state_q == RUN);
    chip_k     = int'(addr_hi_q[3:2]) - CHIP_ID_BASE;
    chip_ok    = (chip_k >= 0) && (chip_k < NUM_CHIPS);
    data_ok    = chip_ok && (int'(addr_hi_q[1:0]) < REGS_PER_CHIP)
                 && (int'(addr_lo_q) < CHARS_PER_REG);
    st_ok      = chip_ok && (int'(addr_hi_q[1:0]) < REGS_PER_CHIP)
                 && (int'(opa_q[1:0]) < STATUS_PER_REG);
    data_idx   = IW'((chip_k*REGS_PER_CHIP + int'(addr_hi_q[1:0]))*CHARS_PER_REG
                     + int'(addr_lo_q));
    st_idx     = IW'(DATA_TOT + (chip_k*REGS_PER_CHIP + int'(addr_hi_q[1:0]))*STATUS_PER_REG
                     + int'(opa_q[1:0]));
    op_rd_data = opa_q inside {OP_SBM, OP_RDM, OP_ADM};
    op_rd_st   = (opa_q[3:2] == 2'b11);
    op_wr_data = (opa_q == OP_WRM);
    op_wr_st   = (opa_q[3:2] == 2'b01);
    op_wmp     = (opa_q == OP_WMP);

    rd_d = '0;
    if (opa_valid_q && running) begin
      if (op_rd_data && data_ok)    rd_d = store_q[data_idx];
      else if (op_rd_st && st_ok)   rd_d = store_q[st_idx];
    end

    // A coincident clr_req beats the write.
    bus_wr  = (cyc_q == X2) && opa_valid_q && running && !clr_req;
    we_data = bus_wr && op_wr_data && data_ok;
    we_st   = bus_wr && op_wr_st && st_ok;
    we_io   = bus_wr && op_wmp && chip_ok;
  end

  // Storage has no reset; the clear walk zeroes it one location per clock.
  always_ff @(posedge clk) begin
    if (!running)     store_q[walk_q[IW-1:0]] <= '0;
    else if (we_data) store_q[data_idx]       <= dbus_in;
    else if (we_st)   store_q[st_idx]         <= dbus_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_q <= '0;
    end else if (clr_req || (!running && walk_q == '0)) begin
      io_q <= '0;
    end else if (we_io) begin
      for (int k = 0; k < NUM_CHIPS; k++)
        if (chip_k == k) io_q[k] <= dbus_in;
    end
  end

  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    if (clr_req) begin
      state_d = CLEAR;
      walk_d  = '0;
    end else if (state_q == CLEAR) begin
      if (walk_q == LAST) begin
        state_d = RUN;
        walk_d  = '0;
      end else begin
        walk_d = walk_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      walk_q  <= '0;
    end else begin
      state_q <= state_d;
      walk_q  <= walk_d;
    end
  end

  assign dbus_out = running ? rd_q : '0;
  assign io_out   = io_q;
  assign busy     = !running;
endmodule
